// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg
// Shared constants and types for the result serializer and its optional
// signature register (enabled with RESULT_SERIALIZER_MISR_EN).
//   WIDTH_DEFAULT : number of compressor result columns per word
//   CNT_W         : width of the beat counter
//   state_e       : serializer FSM states
//   MISR_POLY     : feedback polynomial of the signature register
package result_serializer_pkg;

    localparam int WIDTH_DEFAULT = 53;
    localparam int CNT_W         = 6;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index of the final beat of a word for a given column count.
    function automatic logic [CNT_W-1:0] last_index(input int width);
        return CNT_W'(width - 1);
    endfunction

endpackage

// File: rtl/result_serializer_sig_misr.sv
// sig_misr
// Running multiple-input signature register fed one serial bit per beat.
// Only instantiated when RESULT_SERIALIZER_MISR_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   en       : a beat is being accepted this cycle
//   din      : serial bit being accepted
//   sig      : current signature value
module sig_misr
    import result_serializer_pkg::*;
#(
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] fb_s;

    // Shift left, fold in the polynomial when the old MSB was set, xor in the new bit.
    always_comb begin
        fb_s  = {SIG_W{1'b0}};
        sig_d = sig_q;
        if (sig_q[SIG_W-1]) begin
            fb_s = POLY;
        end else begin
            fb_s = {SIG_W{1'b0}};
        end
        if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb_s ^ {{(SIG_W-1){1'b0}}, din};
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= {SIG_W{1'b0}};
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/result_serializer.sv
// result_serializer
// Captures a WIDTH-column compressor result word and shifts it out one bit
// per accepted beat, column 0 first, with valid/ready handshakes on both
// sides. Words stream gap-free when a new word is offered as the last beat
// of the current one is accepted. Optional MISR signature of all emitted
// beats is compiled in with RESULT_SERIALIZER_MISR_EN.
//   clk, rst     : clock, asynchronous active-high reset
//   src0..src52  : result columns, column k has weight 2^k
//   in_valid     : src columns hold a word to capture
//   in_ready     : a word can be accepted this cycle
//   dout         : serial result bit
//   dout_valid   : dout carries a valid bit
//   dout_last    : dout is column WIDTH-1
//   out_ready    : consumer accepts dout this cycle
//   sig          : running signature (RESULT_SERIALIZER_MISR_EN only)
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SIG_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic src0,  input  logic src1,  input  logic src2,  input  logic src3,
    input  logic src4,  input  logic src5,  input  logic src6,  input  logic src7,
    input  logic src8,  input  logic src9,  input  logic src10, input  logic src11,
    input  logic src12, input  logic src13, input  logic src14, input  logic src15,
    input  logic src16, input  logic src17, input  logic src18, input  logic src19,
    input  logic src20, input  logic src21, input  logic src22, input  logic src23,
    input  logic src24, input  logic src25, input  logic src26, input  logic src27,
    input  logic src28, input  logic src29, input  logic src30, input  logic src31,
    input  logic src32, input  logic src33, input  logic src34, input  logic src35,
    input  logic src36, input  logic src37, input  logic src38, input  logic src39,
    input  logic src40, input  logic src41, input  logic src42, input  logic src43,
    input  logic src44, input  logic src45, input  logic src46, input  logic src47,
    input  logic src48, input  logic src49, input  logic src50, input  logic src51,
    input  logic src52,
    input  logic in_valid,
    output logic in_ready,
    output logic dout,
    output logic dout_valid,
    output logic dout_last,
    input  logic out_ready
`ifdef RESULT_SERIALIZER_MISR_EN
    ,
    output logic [SIG_W-1:0] sig
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = last_index(WIDTH);

    logic [WIDTH-1:0] src_word_s;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] cap_q,        cap_d;
    logic             dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q,  dout_last_d;
    logic             ready_en_q;

    logic             in_ready_s;
    logic             accept_s;
    logic             beat_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign src_word_s = {src52, src51, src50, src49, src48, src47, src46, src45,
                         src44, src43, src42, src41, src40, src39, src38, src37,
                         src36, src35, src34, src33, src32, src31, src30, src29,
                         src28, src27, src26, src25, src24, src23, src22, src21,
                         src20, src19, src18, src17, src16, src15, src14, src13,
                         src12, src11, src10, src9,  src8,  src7,  src6,  src5,
                         src4,  src3,  src2,  src1,  src0};

    // Input side is ready when idle, or when the final beat leaves this cycle.
    // ready_en_q keeps it low until the first edge after reset.
    always_comb begin
        in_ready_s = 1'b0;
        if (!ready_en_q) begin
            in_ready_s = 1'b0;
        end else if (state_q == IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = dout_last_q & out_ready;
        end
    end

    assign accept_s  = in_valid & in_ready_s;
    assign beat_s    = dout_valid_q & out_ready;
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic for the IDLE/SHIFT machine.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = SHIFT;
                    cnt_d        = {CNT_W{1'b0}};
                    cap_d        = src_word_s;
                    dout_d       = src_word_s[0];
                    dout_valid_d = 1'b1;
                    dout_last_d  = (LAST_IDX == {CNT_W{1'b0}});
                end else begin
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (!beat_s) begin
                    // Consumer stalled: everything holds.
                    state_d = SHIFT;
                end else if (dout_last_q && accept_s) begin
                    // Gap-free reload of the next word.
                    state_d      = SHIFT;
                    cnt_d        = {CNT_W{1'b0}};
                    cap_d        = src_word_s;
                    dout_d       = src_word_s[0];
                    dout_valid_d = 1'b1;
                    dout_last_d  = (LAST_IDX == {CNT_W{1'b0}});
                end else if (dout_last_q) begin
                    state_d      = IDLE;
                    cnt_d        = {CNT_W{1'b0}};
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end else begin
                    cnt_d        = cnt_inc_s;
                    dout_d       = cap_q[cnt_inc_s];
                    dout_valid_d = 1'b1;
                    dout_last_d  = (cnt_inc_s == LAST_IDX);
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = {CNT_W{1'b0}};
                dout_d       = 1'b0;
                dout_valid_d = 1'b0;
                dout_last_d  = 1'b0;
            end
        endcase
    end

    // State, capture register and serial output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            cap_q        <= {WIDTH{1'b0}};
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign in_ready   = in_ready_s;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

`ifdef RESULT_SERIALIZER_MISR_EN
    sig_misr #(
        .SIG_W (SIG_W)
    ) u_sig_misr (
        .clk (clk),
        .rst (rst),
        .en  (beat_s),
        .din (dout_q),
        .sig (sig)
    );
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: the driver pushes the expected bit
// stream of every accepted word into a queue, a monitor pops and compares on
// every beat the DUT hands over.
module tb_result_serializer;

    logic        clk;
    logic        rst;
    logic [52:0] src_w;
    logic        in_valid;
    logic        in_ready;
    logic        dout;
    logic        dout_valid;
    logic        dout_last;
    logic        out_ready;
`ifdef RESULT_SERIALIZER_MISR_EN
    logic [15:0] sig;
`endif

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];     // {last, bit}
    bit   rand_bp = 0;
    int   run_cur = 0;
    int   run_max = 0;
    logic [15:0] sig_m = 16'h0000;

    result_serializer dut (
        .clk(clk), .rst(rst),
        .src0(src_w[0]),   .src1(src_w[1]),   .src2(src_w[2]),   .src3(src_w[3]),
        .src4(src_w[4]),   .src5(src_w[5]),   .src6(src_w[6]),   .src7(src_w[7]),
        .src8(src_w[8]),   .src9(src_w[9]),   .src10(src_w[10]), .src11(src_w[11]),
        .src12(src_w[12]), .src13(src_w[13]), .src14(src_w[14]), .src15(src_w[15]),
        .src16(src_w[16]), .src17(src_w[17]), .src18(src_w[18]), .src19(src_w[19]),
        .src20(src_w[20]), .src21(src_w[21]), .src22(src_w[22]), .src23(src_w[23]),
        .src24(src_w[24]), .src25(src_w[25]), .src26(src_w[26]), .src27(src_w[27]),
        .src28(src_w[28]), .src29(src_w[29]), .src30(src_w[30]), .src31(src_w[31]),
        .src32(src_w[32]), .src33(src_w[33]), .src34(src_w[34]), .src35(src_w[35]),
        .src36(src_w[36]), .src37(src_w[37]), .src38(src_w[38]), .src39(src_w[39]),
        .src40(src_w[40]), .src41(src_w[41]), .src42(src_w[42]), .src43(src_w[43]),
        .src44(src_w[44]), .src45(src_w[45]), .src46(src_w[46]), .src47(src_w[47]),
        .src48(src_w[48]), .src49(src_w[49]), .src50(src_w[50]), .src51(src_w[51]),
        .src52(src_w[52]),
        .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .out_ready(out_ready)
`ifdef RESULT_SERIALIZER_MISR_EN
        , .sig(sig)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [52:0] rand53();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[52:0];
    endfunction

    // Signature reference: fold the word's bits, column 0 first.
    function automatic logic [15:0] misr_ref(input logic [15:0] seed, input logic [52:0] w);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < 53; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, w[i]};
        end
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offer word w until it is accepted; while refused, optionally scramble src.
    task automatic send(input logic [52:0] w, input bit garble);
        int n;
        n = 0;
        tick();
        in_valid = 1'b1;
        src_w    = w;
        #1;
        while (!in_ready) begin
            if (garble) src_w = rand53();
            tick();
            src_w = w;
            n++;
            if (n > 3000) begin
                check("send_timeout", 64'd1, 64'd0);
                return;
            end
            #1;
        end
        for (int i = 0; i < 53; i++) exp_q.push_back({(i == 52) ? 1'b1 : 1'b0, w[i]});
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        in_valid = 1'b0;
        #1;
        while (dout_valid || exp_q.size() != 0) begin
            tick();
            #1;
            n++;
            if (n > 3000) begin
                check("idle_timeout", 64'd1, 64'd0);
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_dout_last", {63'd0, dout_last}, 64'd0);
        check("rst_dout", {63'd0, dout}, 64'd0);
`ifdef RESULT_SERIALIZER_MISR_EN
        check("rst_sig", {48'd0, sig}, 64'd0);
`endif
        exp_q.delete();
        sig_m = 16'h0000;
        in_valid = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b0;
        tick();
        #1;
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    endtask

    // Monitor: compare every accepted beat against the scoreboard queue.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                run_cur = 0;
            end else begin
                if (dout_valid) begin
                    run_cur++;
                    if (run_cur > run_max) run_max = run_cur;
                end else begin
                    run_cur = 0;
                end
                if (dout_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_dout", {63'd0, dout}, {63'd0, e[0]});
                        check("beat_last", {63'd0, dout_last}, {63'd0, e[1]});
`ifdef RESULT_SERIALIZER_MISR_EN
                        check("beat_sig", {48'd0, sig}, {48'd0, sig_m});
                        sig_m = {sig_m[14:0], 1'b0} ^ (sig_m[15] ? 16'h1021 : 16'h0000)
                                ^ {15'd0, e[0]};
`endif
                    end
                end
            end
        end
    end

    initial begin
        logic [52:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src_w     = 53'd0;
        #1;
        check("por_dout_valid", {63'd0, dout_valid}, 64'd0);
        check("por_in_ready", {63'd0, in_ready}, 64'd0);
        check("por_dout_last", {63'd0, dout_last}, 64'd0);
        check("por_dout", {63'd0, dout}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b0;
        tick();
        #1;
        check("in_ready_first_edge", {63'd0, in_ready}, 64'd1);

        // Single word with only column 0 set: exact beat timing.
        send(53'd1, 1'b0);
        for (int i = 0; i < 53; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
            #1;
            check("single_valid", {63'd0, dout_valid}, 64'd1);
            check("single_last", {63'd0, dout_last}, (i == 52) ? 64'd1 : 64'd0);
        end
        tick();
        #1;
        check("single_idle_valid", {63'd0, dout_valid}, 64'd0);
        check("single_idle_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back: all ones then alternating, must be one unbroken run.
        run_max = 0;
        send({53{1'b1}}, 1'b0);
        send(53'h0A_AAAA_AAAA_AAAA >> 1, 1'b0);
        wait_idle();
        check("b2b_run", 64'(run_max), 64'd106);

        // Backpressure at beat 10.
        w = rand53();
        send(w, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
        end
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_dout", {63'd0, dout}, {63'd0, w[10]});
            check("stall_valid", {63'd0, dout_valid}, 64'd1);
            check("stall_last", {63'd0, dout_last}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();

        // Reset at beat 20, then a fresh word must start at column 0.
        send(rand53(), 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
        end
        do_reset();
        send(rand53(), 1'b0);
        wait_idle();

        // Ignored input: src keeps changing while the block is busy.
        send(rand53(), 1'b0);
        send(rand53(), 1'b1);
        send(rand53(), 1'b1);
        wait_idle();

`ifdef RESULT_SERIALIZER_MISR_EN
        do_reset();
        send(53'd0, 1'b0);
        send(53'd0, 1'b0);
        wait_idle();
        check("misr_zero", {48'd0, sig}, 64'd0);
        send(53'd1, 1'b0);
        wait_idle();
        check("misr_src0", {48'd0, sig}, {48'd0, misr_ref(16'h0000, 53'd1)});
`endif

        // Random words with random consumer stalls.
        rand_bp = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send(rand53(), ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                in_valid = 1'b0;
            end
        end
        wait_idle();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        tick();
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", {63'd0, dout_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
